// File: rtl/alu_bist_pkg.sv
// Shared types, LFSR constants, op order and the golden ALU model for the ALU self-test sequencer.
package alu_bist_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SETTLE, ST_CHECK, ST_DONE
  } bist_state_t;

  typedef struct packed {
    word_t res;
    logic  zero;
    logic  neg;
    logic  ovf;
  } golden_t;

  localparam word_t LFSR_MASK = 32'h8020_0003;
  localparam int    NUM_OPS   = 10;
  localparam aluop_t OP_ORDER [NUM_OPS] = '{
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU
  };

  // Galois form, shifting right; the mask keeps the state out of zero
  function automatic word_t lfsr_next(word_t x);
    return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic golden_t alu_golden(word_t a, word_t b, aluop_t op);
    golden_t g;
    word_t   r;
    g = '0;
    r = '0;
    case (op)
      ALU_ADD: begin
        r     = a + b;
        g.ovf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        r     = a - b;
        g.ovf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      default:  r = '0;
    endcase
    g.res  = r;
    g.zero = (r == '0);
    g.neg  = r[31];
    return g;
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// ALU operand/result bundle; the sequencer is the master, the ALU under test the slave.
interface alu_bist_if;
  import alu_bist_pkg::*;

  word_t  port_A;
  word_t  port_B;
  aluop_t alu_op;
  word_t  outport;
  logic   zero;
  logic   neg;
  logic   overflow;

  modport master (output port_A, port_B, alu_op, input outport, zero, neg, overflow);
  modport slave  (input port_A, port_B, alu_op, output outport, zero, neg, overflow);
endinterface

// File: rtl/alu_bist_lfsr.sv
// 32-bit operand LFSR; exposes the current and next value and advances two steps per request.
module alu_bist_lfsr
  import alu_bist_pkg::*;
#(
  parameter word_t SEED = 32'hACE1_0001
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  step_i,
  output word_t val_o,
  output word_t nxt_o
);
  localparam word_t SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

  word_t lfsr_q, lfsr_d;

  assign val_o  = lfsr_q;
  assign nxt_o  = lfsr_next(lfsr_q);
  assign lfsr_d = step_i ? lfsr_next(nxt_o) : lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_NZ;
    else     lfsr_q <= lfsr_d;
  end
endmodule

// File: rtl/alu_bist_seq.sv
// ALU self-test sequencer: LFSR operands, fixed op rotation, golden compare, vector/error counts.
// Define ALU_BIST_LOG_EN to capture the first failing vector of each run on fail_*.
module alu_bist_seq
  import alu_bist_pkg::*;
#(
  parameter int    NUM_VEC    = 16,
  parameter int    SETTLE_CYC = 2,
  parameter word_t SEED       = 32'hACE1_0001
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic        start,
  alu_bist_if.master  alu,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] vec_count,
  output logic [15:0] err_count,
  output word_t       fail_a,
  output word_t       fail_b,
  output aluop_t      fail_op,
  output word_t       fail_out
);
  localparam int          SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [15:0] NV  = 16'(NUM_VEC);

  bist_state_t    state_q, state_d;
  word_t          a_q, a_d, b_q, b_d;
  aluop_t         op_q, op_d;
  logic [3:0]     op_idx_q, op_idx_d;
  logic [SCW-1:0] set_q, set_d;
  logic [15:0]    vec_q, vec_d, err_q, err_d;
  word_t          lfsr_val, lfsr_nxt;
  golden_t        gold;
  logic           mism;
  logic           go;

  alu_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (CLOCK_50),
    .rst    (RST),
    .step_i (state_q == ST_LOAD),
    .val_o  (lfsr_val),
    .nxt_o  (lfsr_nxt)
  );

  assign gold = alu_golden(a_q, b_q, op_q);
  // Overflow is only meaningful for signed add/sub
  assign mism = (gold.res != alu.outport) || (gold.zero != alu.zero) || (gold.neg != alu.neg) ||
                (((op_q == ALU_ADD) || (op_q == ALU_SUB)) && (gold.ovf != alu.overflow));
  assign go   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    op_idx_d = op_idx_q;
    set_d    = set_q;
    vec_d    = vec_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d    = '0;
          err_d    = '0;
          op_idx_d = '0;
          state_d  = (NUM_VEC == 0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        a_d     = lfsr_val;
        b_d     = lfsr_nxt;
        op_d    = OP_ORDER[op_idx_q];
        set_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (set_q == SCW'(SETTLE_CYC - 1)) state_d = ST_CHECK;
        else                               set_d   = set_q + 1'b1;
      end
      ST_CHECK: begin
        vec_d    = vec_q + 16'd1;
        if (mism && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        op_idx_d = (op_idx_q == 4'(NUM_OPS - 1)) ? 4'd0 : op_idx_q + 4'd1;
        state_d  = ((vec_q + 16'd1) == NV) ? ST_DONE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      op_idx_q <= '0;
      set_q    <= '0;
      vec_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      op_idx_q <= op_idx_d;
      set_q    <= set_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
    end
  end

`ifdef ALU_BIST_LOG_EN
  word_t  fa_q, fb_q, fo_q;
  aluop_t fop_q;

  // Only the first mismatch of a run is kept
  always_ff @(posedge CLOCK_50) begin
    if (RST || go) begin
      fa_q  <= '0;
      fb_q  <= '0;
      fo_q  <= '0;
      fop_q <= ALU_ADD;
    end else if ((state_q == ST_CHECK) && mism && (err_q == 16'h0)) begin
      fa_q  <= a_q;
      fb_q  <= b_q;
      fo_q  <= alu.outport;
      fop_q <= op_q;
    end
  end

  assign fail_a   = fa_q;
  assign fail_b   = fb_q;
  assign fail_op  = fop_q;
  assign fail_out = fo_q;
`else
  assign fail_a   = '0;
  assign fail_b   = '0;
  assign fail_op  = ALU_ADD;
  assign fail_out = '0;
`endif

  assign alu.port_A = a_q;
  assign alu.port_B = b_q;
  assign alu.alu_op = op_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == 16'h0);
  assign vec_count  = vec_q;
  assign err_count  = err_q;
endmodule

// File: tb/tb_alu_bist_seq.sv
// Bench for alu_bist_seq: a fault-injectable behavioural ALU plus a vector/error reference model.
module tb_alu_bist_seq;
  import alu_bist_pkg::*;

  localparam int          NV_A   = 10;
  localparam int          SET_A  = 2;
  localparam logic [31:0] SEED_V = 32'hACE1_0001;
  localparam aluop_t OPS [10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                                   ALU_NOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  int   fault = 0;
  int   ncmp = 0, nfail = 0;
  logic [31:0] ml;

  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] vec_a, err_a, vec_b, err_b;
  word_t       fa_a, fb_a, fo_a, fa_b, fb_b, fo_b;
  aluop_t      fop_a, fop_b;
  logic [32:0] alu_rv;

  always #10 clk = ~clk;

  alu_bist_if if_a ();
  alu_bist_if if_b ();

  alu_bist_seq #(.NUM_VEC(NV_A), .SETTLE_CYC(SET_A), .SEED(SEED_V)) u_a (
    .CLOCK_50(clk), .RST(rst), .start(start_a), .alu(if_a.master),
    .busy(busy_a), .done(done_a), .pass(pass_a), .vec_count(vec_a), .err_count(err_a),
    .fail_a(fa_a), .fail_b(fb_a), .fail_op(fop_a), .fail_out(fo_a));

  alu_bist_seq #(.NUM_VEC(0), .SETTLE_CYC(1), .SEED(SEED_V)) u_b (
    .CLOCK_50(clk), .RST(rst), .start(start_b), .alu(if_b.master),
    .busy(busy_b), .done(done_b), .pass(pass_b), .vec_count(vec_b), .err_count(err_b),
    .fail_a(fa_b), .fail_b(fb_b), .fail_op(fop_b), .fail_out(fo_b));

  // Reference ALU: 64-bit signed arithmetic, overflow when the truncated result no longer fits
  function automatic logic [32:0] ref_alu(logic [31:0] a, logic [31:0] b, aluop_t op);
    longint      s;
    logic [31:0] r;
    logic        v;
    s = 0; r = 0; v = 1'b0;
    case (op)
      ALU_ADD:  begin s = longint'($signed(a)) + longint'($signed(b)); r = 32'(s); v = (s != longint'($signed(r))); end
      ALU_SUB:  begin s = longint'($signed(a)) - longint'($signed(b)); r = 32'(s); v = (s != longint'($signed(r))); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLL:  r = a << (b % 32);
      ALU_SRL:  r = a >> (b % 32);
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default:  r = 0;
    endcase
    return {v, r};
  endfunction

  // ALU presented to the DUT: 1 = ADD bit0 flipped, 2 = ADD/SUB ovf flipped, 3 = ovf flipped elsewhere
  function automatic logic [32:0] alu_dut(logic [31:0] a, logic [31:0] b, aluop_t op, int mode);
    logic [32:0] rv;
    logic        as;
    rv = ref_alu(a, b, op);
    as = (op == ALU_ADD) || (op == ALU_SUB);
    if (mode == 1 && op == ALU_ADD) rv[0]  = ~rv[0];
    if (mode == 2 && as)            rv[32] = ~rv[32];
    if (mode == 3 && !as)           rv[32] = ~rv[32];
    return rv;
  endfunction

  function automatic logic [31:0] lstep(logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  assign alu_rv         = alu_dut(if_a.port_A, if_a.port_B, if_a.alu_op, fault);
  assign if_a.outport   = alu_rv[31:0];
  assign if_a.zero      = (alu_rv[31:0] == 32'h0);
  assign if_a.neg       = alu_rv[31];
  assign if_a.overflow  = alu_rv[32];
  assign if_b.outport   = '0;
  assign if_b.zero      = 1'b0;
  assign if_b.neg       = 1'b0;
  assign if_b.overflow  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input int mode, input string tag);
    logic [31:0] va [NV_A];
    logic [31:0] vb [NV_A];
    aluop_t      vo [NV_A];
    logic [32:0] e, g;
    logic [31:0] xa, xb, xo;
    aluop_t      xop;
    int          errs, n, k;
    fault = mode; errs = 0; xa = 0; xb = 0; xo = 0; xop = ALU_ADD;
    for (int i = 0; i < NV_A; i++) begin
      va[i] = ml; ml = lstep(ml);
      vb[i] = ml; ml = lstep(ml);
      vo[i] = OPS[i % 10];
      e = ref_alu(va[i], vb[i], vo[i]);
      g = alu_dut(va[i], vb[i], vo[i], mode);
      if (g[31:0] != e[31:0] || ((vo[i] == ALU_ADD || vo[i] == ALU_SUB) && g[32] != e[32])) begin
        if (errs == 0) begin xa = va[i]; xb = vb[i]; xop = vo[i]; xo = g[31:0]; end
        errs++;
      end
    end
    start_a = 1'b1; step(); start_a = 1'b0; n = 1; k = 0;
    chk({tag, ".busy_start"}, 32'(busy_a), 32'd1);
    while (!done_a && n < 400) begin
      step(); n++;
      if (k < NV_A && n == 2 + 4 * k) begin
        chk($sformatf("%s.A%0d", tag, k), if_a.port_A, va[k]);
        chk($sformatf("%s.B%0d", tag, k), if_a.port_B, vb[k]);
        chk($sformatf("%s.op%0d", tag, k), 32'(if_a.alu_op), 32'(vo[k]));
        chk($sformatf("%s.busy%0d", tag, k), 32'(busy_a), 32'd1);
        k++;
      end
    end
    chk({tag, ".done_cycle"}, n, 1 + NV_A * (SET_A + 2));
    chk({tag, ".vec"}, 32'(vec_a), NV_A);
    chk({tag, ".err"}, 32'(err_a), errs);
    chk({tag, ".pass"}, 32'(pass_a), (errs == 0) ? 32'd1 : 32'd0);
    chk({tag, ".busy_end"}, 32'(busy_a), 32'd0);
`ifdef ALU_BIST_LOG_EN
    chk({tag, ".fail_a"}, fa_a, xa);
    chk({tag, ".fail_b"}, fb_a, xb);
    chk({tag, ".fail_op"}, 32'(fop_a), 32'(xop));
    chk({tag, ".fail_out"}, fo_a, xo);
`else
    chk({tag, ".fail_a"}, fa_a, 32'd0);
    chk({tag, ".fail_out"}, fo_a, 32'd0);
`endif
  endtask

  initial begin
    ml = SEED_V;
    // 1: reset
    step(); step();
    chk("rst.busy", 32'(busy_a), 0);
    chk("rst.done", 32'(done_a), 0);
    chk("rst.pass", 32'(pass_a), 0);
    chk("rst.vec", 32'(vec_a), 0);
    chk("rst.err", 32'(err_a), 0);
    chk("rst.portA", if_a.port_A, 0);
    chk("rst.portB", if_a.port_B, 0);
    chk("rst.op", 32'(if_a.alu_op), 0);
    chk("rst.fail_a", fa_a, 0);
    chk("rst.fail_out", fo_a, 0);
    chk("rst.done_b", 32'(done_b), 0);
    rst = 1'b0;
    step();
    chk("idle.busy", 32'(busy_a), 0);

    // 2..4: golden, ADD bit fault, overflow faults; LFSR carries across runs
    run_a(0, "golden");
    run_a(1, "addbit");
    run_a(2, "ovf_addsub");
    run_a(3, "ovf_other");

    // 5: start ignored mid-run, then reset at cycle 15
    fault = 0;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int n = 2; n <= 10; n++) step();
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("mid.vec_kept", 32'(vec_a), 2);
    chk("mid.busy", 32'(busy_a), 1);
    step(); step(); step();
    rst = 1'b1; step(); step(); rst = 1'b0;
    ml = SEED_V;
    chk("midrst.busy", 32'(busy_a), 0);
    chk("midrst.done", 32'(done_a), 0);
    chk("midrst.vec", 32'(vec_a), 0);
    chk("midrst.err", 32'(err_a), 0);
    chk("midrst.portA", if_a.port_A, 0);
    run_a(1, "after_rst");

    // 6: NUM_VEC = 0 finishes one cycle after start
    chk("nv0.done_pre", 32'(done_b), 0);
    start_b = 1'b1; step(); start_b = 1'b0;
    chk("nv0.done", 32'(done_b), 1);
    chk("nv0.pass", 32'(pass_b), 1);
    chk("nv0.vec", 32'(vec_b), 0);
    chk("nv0.busy", 32'(busy_b), 0);
    start_b = 1'b1; step(); start_b = 1'b0;
    chk("nv0.redo", 32'(done_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
